// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-port register file with pending-write scoreboard
//
// Purpose:
//   Integer register file for the CPU datapath. Any number of combinational
//   read ports, prioritised write ports (highest index wins on an address
//   collision), optional same-cycle write-to-read bypass and a hardwired zero
//   register. A per-register pending bit lets issue logic reserve a
//   destination, observe in-flight operands and squash all reservations.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_rd_addr[r]     read index per read port
//   o_rd_data[r]     read data per read port (combinational)
//   o_rd_ready[r]    register has no outstanding reservation
//   i_wr_en[p]       write request per write port
//   i_wr_addr[p]     write index per write port
//   i_wr_data[p]     write data per write port
//   o_wr_done[p]     this port's write commits on the next edge
//   i_rsv_en         reserve i_rsv_addr as a pending destination
//   i_rsv_addr       register to reserve
//   o_rsv_ack        reservation accepted this cycle
//   i_flush          clear all reservations, data untouched
//   o_pending_count  registered number of reserved registers

module register_file_sb #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGISTERS   = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 1,
  parameter int BYPASS          = 1,
  localparam int IDX_W = $clog2(NUM_REGISTERS),
  localparam int CNT_W = $clog2(NUM_REGISTERS + 1)
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic [NUM_READ_PORTS-1:0][IDX_W-1:0]       i_rd_addr,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  o_rd_data,
  output logic [NUM_READ_PORTS-1:0]                  o_rd_ready,
  input  logic [NUM_WRITE_PORTS-1:0]                 i_wr_en,
  input  logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]      i_wr_addr,
  input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_WRITE_PORTS-1:0]                 o_wr_done,
  input  logic                                       i_rsv_en,
  input  logic [IDX_W-1:0]                           i_rsv_addr,
  output logic                                       o_rsv_ack,
  input  logic                                       i_flush,
  output logic [CNT_W-1:0]                           o_pending_count
);

  // Storage. Entry 0 is reset and never written, so it stays zero.
  logic [DATA_WIDTH-1:0]    r_data [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] r_pending;
  logic [CNT_W-1:0]         r_pending_count;

  logic [NUM_WRITE_PORTS-1:0] w_wr_valid;
  logic [NUM_WRITE_PORTS-1:0] w_wr_done;
  logic [NUM_REGISTERS-1:0]   w_clear;
  logic [NUM_REGISTERS-1:0]   w_set;
  logic [NUM_REGISTERS-1:0]   w_pending_next;
  logic [CNT_W-1:0]           w_pending_cnt;
  logic                       w_rsv_ack;

  // A write to x0 is not a write at all: it neither commits nor blocks
  // a lower-priority port.
  always_comb begin
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      w_wr_valid[p] = i_wr_en[p] && (i_wr_addr[p] != '0);
    end
  end

  // A valid port wins unless a higher-index valid port targets the same
  // register. Winners therefore always target distinct registers.
  always_comb begin
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      w_wr_done[p] = w_wr_valid[p];
      for (int q = p + 1; q < NUM_WRITE_PORTS; q++) begin
        if (w_wr_valid[q] && (i_wr_addr[q] == i_wr_addr[p])) begin
          w_wr_done[p] = 1'b0;
        end
      end
    end
  end

  // Registers whose reservation is released by a committing write.
  always_comb begin
    w_clear = '0;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (w_wr_done[p]) begin
        w_clear[i_wr_addr[p]] = 1'b1;
      end
    end
  end

  // A register being released this cycle may be re-reserved in the same
  // cycle; x0 reservations are always accepted but leave no trace.
  always_comb begin
    w_rsv_ack = i_rsv_en && !i_flush &&
                ((i_rsv_addr == '0) || !r_pending[i_rsv_addr] || w_clear[i_rsv_addr]);
  end

  always_comb begin
    w_set = '0;
    if (w_rsv_ack && (i_rsv_addr != '0)) begin
      w_set[i_rsv_addr] = 1'b1;
    end
  end

  // Set dominates clear so a same-cycle write-back and re-issue keep the
  // register pending for the new producer.
  always_comb begin
    if (i_flush) begin
      w_pending_next = '0;
    end else begin
      w_pending_next = (r_pending & ~w_clear) | w_set;
    end
    w_pending_next[0] = 1'b0;
  end

  always_comb begin
    w_pending_cnt = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      w_pending_cnt = w_pending_cnt + CNT_W'(w_pending_next[i]);
    end
  end

  // Read ports. Bypass is suppressed while in reset so reads hold at zero
  // even if a write is being presented.
  always_comb begin
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      o_rd_data[r]  = r_data[i_rd_addr[r]];
      o_rd_ready[r] = !r_pending[i_rd_addr[r]];
      if ((BYPASS != 0) && i_rst_n) begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (w_wr_done[p] && (i_wr_addr[p] == i_rd_addr[r])) begin
            o_rd_data[r] = i_wr_data[p];
          end
        end
        if (w_clear[i_rd_addr[r]]) begin
          o_rd_ready[r] = 1'b1;
        end
      end
      if (i_rd_addr[r] == '0) begin
        o_rd_data[r]  = '0;
        o_rd_ready[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (w_wr_done[p]) begin
          r_data[i_wr_addr[p]] <= i_wr_data[p];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending       <= '0;
      r_pending_count <= '0;
    end else begin
      r_pending       <= w_pending_next;
      r_pending_count <= w_pending_cnt;
    end
  end

  assign o_wr_done       = w_wr_done;
  assign o_rsv_ack       = w_rsv_ack;
  assign o_pending_count = r_pending_count;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb

module tb_register_file_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRP = 2;
  localparam int NWP = 2;
  localparam int IW  = 5;
  localparam int CW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic [NRP-1:0][IW-1:0]   rd_addr;
  logic [NRP-1:0][DW-1:0]   rd_data;
  logic [NRP-1:0]           rd_ready;
  logic [NWP-1:0]           wr_en;
  logic [NWP-1:0][IW-1:0]   wr_addr;
  logic [NWP-1:0][DW-1:0]   wr_data;
  logic [NWP-1:0]           wr_done;
  logic                     rsv_en;
  logic [IW-1:0]            rsv_addr;
  logic                     rsv_ack;
  logic                     flush;
  logic [CW-1:0]            pending_count;

  register_file_sb #(
    .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(NRP),
    .NUM_WRITE_PORTS(NWP), .BYPASS(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_ready(rd_ready),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_done(wr_done),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_ack(rsv_ack),
    .i_flush(flush), .o_pending_count(pending_count)
  );

  // Reference model: architectural contents and the set of reserved registers.
  logic [DW-1:0] m_data [NR];
  bit            m_pend [NR];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_data[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic bit port_valid(int p);
    return wr_en[p] && (wr_addr[p] != 0);
  endfunction

  function automatic bit port_wins(int p);
    if (!port_valid(p)) return 1'b0;
    for (int q = p + 1; q < NWP; q++)
      if (port_valid(q) && wr_addr[q] == wr_addr[p]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit reg_released(int a);
    for (int p = 0; p < NWP; p++)
      if (port_wins(p) && wr_addr[p] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_ack();
    return rsv_en && !flush &&
           (rsv_addr == 0 || !m_pend[rsv_addr] || reg_released(rsv_addr));
  endfunction

  function automatic logic [DW-1:0] exp_rd(int r);
    int a;
    a = rd_addr[r];
    if (a == 0) return '0;
    if (rst_n)
      for (int p = 0; p < NWP; p++)
        if (port_wins(p) && wr_addr[p] == a) return wr_data[p];
    return m_data[a];
  endfunction

  function automatic bit exp_rdy(int r);
    int a;
    a = rd_addr[r];
    return (a == 0) || !m_pend[a] || (rst_n && reg_released(a));
  endfunction

  function automatic int pend_total();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) n += m_pend[i];
    return n;
  endfunction

  task automatic check_comb();
    for (int p = 0; p < NWP; p++)
      chk($sformatf("wr_done[%0d]", p), wr_done[p], port_wins(p));
    chk("rsv_ack", rsv_ack, exp_ack());
    for (int r = 0; r < NRP; r++) begin
      chk($sformatf("rd_data[%0d]@x%0d", r, rd_addr[r]), rd_data[r], exp_rd(r));
      chk($sformatf("rd_ready[%0d]@x%0d", r, rd_addr[r]), rd_ready[r], exp_rdy(r));
    end
    chk("pending_count", pending_count, pend_total());
  endtask

  // Apply the effect of one rising edge with the current inputs.
  task automatic commit();
    bit ack;
    ack = exp_ack();
    for (int p = 0; p < NWP; p++)
      if (port_wins(p)) m_data[wr_addr[p]] = wr_data[p];
    if (flush) begin
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end else begin
      for (int p = 0; p < NWP; p++)
        if (port_wins(p)) m_pend[wr_addr[p]] = 1'b0;
      if (ack && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    if (rst_n) commit();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    model_reset();

    // Every register reads zero and ready while reset is held.
    #2;
    for (int a = 0; a < NR; a++) begin
      rd_addr[0] = IW'(a);
      rd_addr[1] = IW'(NR - 1 - a);
      #1;
      chk("rst_rd_data0", rd_data[0], 0);
      chk("rst_rd_ready0", rd_ready[0], 1);
      check_comb();
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // x5 <= DEADBEEF, then asynchronous reset during a second write.
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5;
    cycle();
    idle(); #1;
    chk("x5_written", rd_data[0], 32'hDEADBEEF);
    wr_en = 2'b01; wr_data[0] = 32'h0BADF00D;
    #2;
    rst_n = 1'b0; model_reset();
    #1;
    chk("x5_async_clear", rd_data[0], 0);
    chk("rst_wr_done_follows", wr_done[0], 1);
    chk("rst_pending_count", pending_count, 0);
    check_comb();
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("x5_after_reset", rd_data[0], 0);

    // Write x7 with bypass, then x0 write is ignored.
    wr_en = 2'b01; wr_addr[0] = 7; wr_data[0] = 32'hA5A5A5A5; rd_addr[0] = 7; #1;
    chk("x7_bypass", rd_data[0], 32'hA5A5A5A5);
    cycle();
    idle(); #1;
    chk("x7_stored", rd_data[0], 32'hA5A5A5A5);
    wr_en = 2'b01; wr_addr[0] = 0; wr_data[0] = 32'h1234; rd_addr[0] = 0; #1;
    chk("x0_wr_done", wr_done[0], 0);
    chk("x0_read", rd_data[0], 0);
    cycle();

    // Both ports write x3: port 1 wins.
    wr_en = 2'b11; wr_addr[0] = 3; wr_addr[1] = 3;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; #1;
    chk("x3_collide_done", wr_done, 2'b10);
    cycle();
    idle(); rd_addr[0] = 3; #1;
    chk("x3_winner", rd_data[0], 32'h22);

    // Reserve x9, re-reserve refused, write releases.
    rsv_en = 1'b1; rsv_addr = 9; rd_addr[0] = 9; #1;
    chk("x9_rsv_ack", rsv_ack, 1);
    cycle();
    chk("x9_not_ready", rd_ready[0], 0);
    chk("x9_count1", pending_count, 1);
    chk("x9_rersv_nack", rsv_ack, 0);
    cycle();
    rsv_en = 1'b0; wr_en = 2'b01; wr_addr[0] = 9; wr_data[0] = 32'h99; #1;
    chk("x9_ready_bypass", rd_ready[0], 1);
    cycle();
    idle(); #1;
    chk("x9_ready_after_wr", rd_ready[0], 1);
    chk("x9_count0", pending_count, 0);

    // Write-back and re-reserve of x9 in the same cycle.
    rsv_en = 1'b1; rsv_addr = 9;
    cycle();
    wr_en = 2'b01; wr_addr[0] = 9; wr_data[0] = 32'h77; #1;
    chk("x9_same_cycle_ack", rsv_ack, 1);
    cycle();
    idle(); #1;
    chk("x9_still_pending", rd_ready[0], 0);
    chk("x9_count_same", pending_count, 1);
    chk("x9_new_data", rd_data[0], 32'h77);
    wr_en = 2'b01; wr_addr[0] = 9; wr_data[0] = 32'h78;
    cycle();
    idle();

    // Reserve x1..x3 then flush against a reservation of x4.
    for (int a = 1; a <= 3; a++) begin
      rsv_en = 1'b1; rsv_addr = IW'(a);
      cycle();
    end
    rsv_en = 1'b0; #1;
    chk("count3", pending_count, 3);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 4; #1;
    chk("flush_nack", rsv_ack, 0);
    cycle();
    idle(); #1;
    chk("flush_count0", pending_count, 0);
    for (int a = 1; a <= 4; a++) begin
      rd_addr[1] = IW'(a); #1;
      chk($sformatf("flush_ready_x%0d", a), rd_ready[1], 1);
    end
    rd_addr[0] = 3; rd_addr[1] = 7; #1;
    chk("flush_keeps_x3", rd_data[0], 32'h22);
    chk("flush_keeps_x7", rd_data[1], 32'hA5A5A5A5);

    // Randomized traffic concentrated on a few registers to force collisions.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NWP; p++) begin
        wr_en[p]   = ($urandom_range(0, 2) != 0);
        wr_addr[p] = IW'($urandom_range(0, 7));
        wr_data[p] = $urandom;
      end
      rsv_en   = ($urandom_range(0, 1) != 0);
      rsv_addr = IW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < NRP; r++)
        rd_addr[r] = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, NR - 1))
                                                 : IW'($urandom_range(0, 7));
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the CPU datapath. Provides any number of combinational read ports and prioritised write ports, optional same-cycle write-to-read bypass, and a hardwired zero register. The scoreboard lets issue logic reserve a destination register, see which operands are still in flight, and flush all reservations on a pipeline squash.

## Interface
- DATA_WIDTH, 32, bits per register
- NUM_REGISTERS, 32, register count, power of two ≥ 2; register 0 is hardwired to zero
- NUM_READ_PORTS, 2, read ports, ≥ 1
- NUM_WRITE_PORTS, 1, write ports, ≥ 1; higher port index has higher priority
- BYPASS, 1, 1 = reads see same-cycle committing write data; 0 = no bypass
- IDX_W (local), $clog2(NUM_REGISTERS)
- CNT_W (local), $clog2(NUM_REGISTERS+1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr[NUM_READ_PORTS]  in  IDX_W  read register index per port
- rd_data[NUM_READ_PORTS]  out  DATA_WIDTH  read data per port
- rd_ready[NUM_READ_PORTS]  out  1  register has no outstanding reservation
- wr_en[NUM_WRITE_PORTS]  in  1  write request per port
- wr_addr[NUM_WRITE_PORTS]  in  IDX_W  write index per port
- wr_data[NUM_WRITE_PORTS]  in  DATA_WIDTH  write data per port
- wr_done[NUM_WRITE_PORTS]  out  1  this port's write commits on the next edge
- rsv_en  in  1  request to reserve rsv_addr as a pending destination
- rsv_addr  in  IDX_W  register to reserve
- rsv_ack  out  1  reservation accepted this cycle
- flush  in  1  clear all reservations (data untouched)
- pending_count  out  CNT_W  number of reserved registers

## Operation
- Storage: data[1..NUM_REGISTERS-1] flops; data[0] reads as 0 and is never written. pending[1..N-1] bits; pending[0] is constantly 0.
- Write arbitration: port p is valid if wr_en[p] and wr_addr[p] != 0. wr_done[p] = valid and no higher-index valid port targets the same address. Only winning ports update data; lower-priority same-address writes are dropped.
- Read: rd_data = data[rd_addr]. With BYPASS=1, if some port has wr_done and a matching address, rd_data returns that port's wr_data instead. Address 0 always returns 0.
- rd_ready = !pending[rd_addr], except that with BYPASS=1 a register being cleared by a committing write this cycle reads ready. Address 0 is always ready.
- Clearing a reservation: any wr_done write to address a clears pending[a] on the edge. Writes to unreserved registers are legal and commit normally.
- Reserving: rsv_ack = rsv_en and (rsv_addr == 0, or !pending[rsv_addr], or pending[rsv_addr] is being cleared this cycle) and !flush.
  - When acked with rsv_addr != 0, pending[rsv_addr] is set on the edge.
  - A set and a clear on the same register in the same cycle leave it set.
  - An acked reservation of register 0 changes no state.
- flush: all pending bits go to 0 on the edge; rsv_ack is forced to 0; writes still commit.
- pending_count is the registered population count of pending, updated on the same edge as pending.

## Timing
- Reset (rst_n low, asynchronous): data, pending, and pending_count go to 0 immediately. Consequently rd_data = 0, rd_ready = 1, and pending_count = 0 while reset is held. wr_done and rsv_ack remain combinational and follow their inputs.
- Reset assertion mid-operation discards any in-flight write or reservation. State updates resume on the first rising edge after rst_n returns high.
- Read latency: 0 cycles (combinational). A write is visible on reads the cycle after its edge, or in the same cycle when BYPASS=1.
- Reservation latency: rd_ready drops the cycle after rsv_ack. pending_count changes the cycle after the event.
- Combinational paths: rd_addr → rd_data and rd_ready; wr_* → wr_done, rsv_ack, and (when BYPASS=1) rd_data and rd_ready.

## Test plan
- Reset then read all registers: every rd_data = 0, rd_ready = 1, pending_count = 0. Asserting rst_n low mid-write clears register 5 that previously held 0xDEADBEEF without waiting for a clock edge.
- Write 0xA5A5A5A5 to x7 on port 0. Same cycle: rd_data for x7 = 0xA5A5A5A5 when BYPASS=1, 0 when BYPASS=0. Next cycle: 0xA5A5A5A5 for both settings. Writing 0x1234 to x0 gives wr_done = 0 and x0 still reads 0.
- NUM_WRITE_PORTS=2, both ports write x3 (port 0 → 0x11, port 1 → 0x22): wr_done = {1, 0} for ports {1, 0}, and x3 = 0x22 afterwards.
- Reserve x9: rsv_ack = 1; next cycle rd_ready(x9) = 0 and pending_count = 1. Re-reserving x9 gives rsv_ack = 0. A write to x9 restores rd_ready = 1 and pending_count = 0.
- Write-clear and re-reserve of x9 in the same cycle: rsv_ack = 1, x9 stays pending, pending_count is unchanged, and the new data is stored.
- Reserve x1, x2, x3 (pending_count = 3), then assert flush together with rsv_en for x4: rsv_ack = 0, pending_count = 0 next cycle, all rd_ready = 1, and data is unchanged.
